// File: rtl/spi_bus_arbiter.sv
// rtl/spi_bus_arbiter.sv - lock-qualified round-robin SPI bus arbiter with per-requester SCK rate
module spi_bus_arbiter #(
    parameter int NREQ      = 3,
    parameter int LOCK_WAIT = 64,
    parameter int CS_SETUP  = 2,
    parameter int CS_GUARD  = 4
) (
    input  logic                clk_160,
    input  logic                rst,
    input  logic                pll_lock,
    input  logic [NREQ-1:0]     req,
    input  logic [2*NREQ-1:0]   req_div,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     cs_n,
    output logic                sck,
    output logic                sck_rise,
    output logic                sck_fall,
    output logic                ready,
    output logic                abort
);

    localparam int CMAX_A = (LOCK_WAIT > CS_SETUP) ? LOCK_WAIT : CS_SETUP;
    localparam int CMAX_B = (CS_GUARD > 16) ? CS_GUARD : 16;
    localparam int CMAX   = (CMAX_A > CMAX_B) ? CMAX_A : CMAX_B;
    localparam int CW     = $clog2(CMAX + 1);
    localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        IDLE      = 3'd1,
        SETUP     = 3'd2,
        ACTIVE    = 3'd3,
        HOLD      = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    last_q, last_d;
    logic [1:0]       div_q, div_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  cs_n_q, cs_n_d;
    logic             sck_q, sck_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             ready_q, ready_d;
    logic             abort_q, abort_d;

    logic             found;
    logic [IW-1:0]    sel;
    logic [1:0]       div_sel;
    logic [NREQ-1:0]  sel_onehot;
    logic             req_cur;

    // Half-period length minus one, so a toggle fires when cnt_q reaches it
    function automatic logic [CW-1:0] half_lim(input logic [1:0] code);
        case (code)
            2'd0:    return CW'(0);
            2'd1:    return CW'(1);
            2'd2:    return CW'(7);
            default: return CW'(15);
        endcase
    endfunction

    // Two passes: indices above last_q first, then wrap to the low indices
    always_comb begin
        found = 1'b0;
        sel   = last_q;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && req[j] && (j > int'(last_q))) begin
                found = 1'b1;
                sel   = IW'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!found && req[j] && (j <= int'(last_q))) begin
                found = 1'b1;
                sel   = IW'(j);
            end
        end
    end

    always_comb begin
        div_sel    = 2'd0;
        sel_onehot = '0;
        req_cur    = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (sel == IW'(j)) begin
                div_sel       = req_div[2*j +: 2];
                sel_onehot[j] = 1'b1;
            end
            if (idx_q == IW'(j)) begin
                req_cur = req[j];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        div_d   = div_q;
        gnt_d   = gnt_q;
        cs_n_d  = cs_n_q;
        sck_d   = sck_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        ready_d = ready_q;
        abort_d = 1'b0;

        // Lock loss outranks every other decision made in this cycle
        if ((state_q != WAIT_LOCK) && !pll_lock) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            gnt_d   = '0;
            cs_n_d  = '1;
            sck_d   = 1'b0;
            ready_d = 1'b0;
            abort_d = (state_q == SETUP) || (state_q == ACTIVE);
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (!pll_lock) begin
                        cnt_d = '0;
                    end else if (cnt_q == CW'(LOCK_WAIT - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                IDLE: begin
                    if (found) begin
                        state_d = SETUP;
                        cnt_d   = '0;
                        idx_d   = sel;
                        div_d   = div_sel;
                        gnt_d   = sel_onehot;
                        cs_n_d  = ~sel_onehot;
                    end
                end
                SETUP: begin
                    if (!req_cur) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                        gnt_d   = '0;
                        cs_n_d  = '1;
                    end else if (cnt_q == CW'(CS_SETUP - 1)) begin
                        state_d = ACTIVE;
                        cnt_d   = '0;
                        sck_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ACTIVE: begin
                    if (!req_cur && !sck_q) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                        gnt_d   = '0;
                        cs_n_d  = '1;
                    end else if (cnt_q == half_lim(div_q)) begin
                        cnt_d  = '0;
                        sck_d  = ~sck_q;
                        rise_d = ~sck_q;
                        fall_d = sck_q;
                        // Released while high: this falling edge also closes the grant
                        if (!req_cur) begin
                            state_d = HOLD;
                            gnt_d   = '0;
                            cs_n_d  = '1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt_q == CW'(CS_GUARD - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        last_d  = idx_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    gnt_d   = '0;
                    cs_n_d  = '1;
                    sck_d   = 1'b0;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_160) begin
        if (rst) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= IW'(NREQ - 1);
            div_q   <= 2'd0;
            gnt_q   <= '0;
            cs_n_q  <= '1;
            sck_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            ready_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            div_q   <= div_d;
            gnt_q   <= gnt_d;
            cs_n_q  <= cs_n_d;
            sck_q   <= sck_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            ready_q <= ready_d;
            abort_q <= abort_d;
        end
    end

    assign gnt      = gnt_q;
    assign cs_n     = cs_n_q;
    assign sck      = sck_q;
    assign sck_rise = rise_q;
    assign sck_fall = fall_q;
    assign ready    = ready_q;
    assign abort    = abort_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb/tb_spi_bus_arbiter.sv - self-checking bench for spi_bus_arbiter
module tb_spi_bus_arbiter;

    localparam int NREQ      = 3;
    localparam int LOCK_WAIT = 64;
    localparam int CS_SETUP  = 2;
    localparam int CS_GUARD  = 4;

    logic        clk_160 = 1'b0;
    logic        rst;
    logic        pll_lock;
    logic [2:0]  req;
    logic [5:0]  req_div;
    logic [2:0]  gnt;
    logic [2:0]  cs_n;
    logic        sck;
    logic        sck_rise;
    logic        sck_fall;
    logic        ready;
    logic        abort;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_q[$];

    spi_bus_arbiter #(
        .NREQ(NREQ), .LOCK_WAIT(LOCK_WAIT), .CS_SETUP(CS_SETUP), .CS_GUARD(CS_GUARD)
    ) dut (
        .clk_160(clk_160), .rst(rst), .pll_lock(pll_lock), .req(req), .req_div(req_div),
        .gnt(gnt), .cs_n(cs_n), .sck(sck), .sck_rise(sck_rise), .sck_fall(sck_fall),
        .ready(ready), .abort(abort)
    );

    always #5 clk_160 = ~clk_160;
    always @(posedge clk_160) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk_160);
        #1;
    endtask

    task automatic bring_up();
        pll_lock = 1'b1;
        repeat (LOCK_WAIT) tick();
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL bring_up_ready got=%0b exp=1", ready);
        end
    endtask

    task automatic wait_cs_low(input int i, output int t);
        t = -1;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (cs_n[i] === 1'b0) begin
                t = cyc;
                break;
            end
        end
        checks++;
        if (t < 0) begin
            failures++;
            $display("FAIL wait_cs_low[%0d] timeout got=%b exp=cs_n[%0d]=0", i, cs_n, i);
        end
    endtask

    task automatic wait_rise(output int t);
        t = -1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (sck_rise === 1'b1) begin
                t = cyc;
                break;
            end
        end
        checks++;
        if (t < 0) begin
            failures++;
            $display("FAIL wait_rise timeout got=no_rise exp=rise");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pll_lock = 1'b0; req = 3'b000; req_div = 6'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({gnt, cs_n, sck, sck_rise, sck_fall, ready, abort} !== {3'b000, 3'b111, 5'b00000}) begin
            failures++;
            $display("FAIL reset_outputs got=%b_%b_%b%b%b%b%b exp=000_111_00000",
                     gnt, cs_n, sck, sck_rise, sck_fall, ready, abort);
        end
    endtask

    task automatic test_lock_qualify();
        pll_lock = 1'b1;
        repeat (LOCK_WAIT - 1) tick();
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL lock_63_high got=%0b exp=0", ready); end
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        repeat (LOCK_WAIT - 1) tick();
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL lock_rerise_63 got=%0b exp=0", ready); end
        tick();
        checks++;
        if (ready !== 1'b1) begin failures++; $display("FAIL lock_rerise_64 got=%0b exp=1", ready); end
    endtask

    task automatic test_round_robin();
        int cur, rises, gap, done, idxg, e;
        bit in_gap;
        req_div = 6'b0;
        req = 3'b111;
        exp_q = {};
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0);
        cur = -1; rises = 0; gap = 0; done = 0; in_gap = 1'b0;
        for (int c = 0; c < 2000 && done < 4; c++) begin
            tick();
            checks++;
            if ((cs_n !== ~gnt) || ($countones(gnt) > 1)) begin
                failures++;
                $display("FAIL rr_onehot got=gnt%b_cs%b exp=onehot_complement", gnt, cs_n);
            end
            if ((gnt != 3'b000) && (cur < 0)) begin
                idxg = gnt[0] ? 0 : (gnt[1] ? 1 : 2);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                checks++;
                if (idxg != e) begin
                    failures++;
                    $display("FAIL rr_order got=%0d exp=%0d", idxg, e);
                end
                // cs_n stays high for the guard cycles plus the IDLE arbitration cycle
                if (in_gap) begin
                    checks++;
                    if (gap != CS_GUARD + 1) begin
                        failures++;
                        $display("FAIL rr_cs_gap got=%0d exp=%0d", gap, CS_GUARD + 1);
                    end
                end
                cur = idxg; rises = 0; in_gap = 1'b0;
            end else if ((gnt == 3'b000) && (cur >= 0)) begin
                done++; cur = -1; gap = 1; in_gap = 1'b1;
                req = (done < 4) ? 3'b111 : 3'b000;
            end else if (in_gap && (cs_n == 3'b111)) begin
                gap++;
            end
            if ((cur >= 0) && sck_rise) begin
                rises++;
                if (rises == 4) req[cur] = 1'b0;
            end
        end
        checks++;
        if ((done != 4) || (exp_q.size() != 0)) begin
            failures++;
            $display("FAIL rr_complete got=%0d_left%0d exp=4_left0", done, exp_q.size());
        end
        repeat (CS_GUARD + 2) tick();
    endtask

    task automatic test_speed();
        int t0, n, e;
        req_div = 6'b00_10_00;
        req = 3'b010;
        wait_cs_low(1, t0);
        exp_q = {};
        for (int k = 0; k < 4; k++) exp_q.push_back(t0 + CS_SETUP + 8 + 16 * k);
        n = 0;
        for (int c = 0; c < 200 && n < 4; c++) begin
            tick();
            if (sck_rise === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (cyc != e) begin
                    failures++;
                    $display("FAIL speed_rise%0d got=%0d exp=%0d", n, cyc, e);
                end
                n++;
                if (n == 1) req_div = 6'b00_00_00;
            end
        end
        checks++;
        if (n != 4) begin failures++; $display("FAIL speed_rise_count got=%0d exp=4", n); end
        req = 3'b000;
        for (int c = 0; c < 40 && gnt != 3'b000; c++) tick();
        repeat (CS_GUARD + 2) tick();
    endtask

    task automatic test_release();
        int t0, tr, tf, extra;
        req_div = 6'b11_00_00;
        req = 3'b100;
        wait_cs_low(2, t0);
        wait_rise(tr);
        repeat (3) tick();
        req = 3'b000;
        tf = -1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (sck_fall === 1'b1) begin tf = cyc; break; end
        end
        checks++;
        if (tf != tr + 16) begin failures++; $display("FAIL release_fall got=%0d exp=%0d", tf, tr + 16); end
        checks++;
        if ((cs_n !== 3'b111) || (gnt !== 3'b000)) begin
            failures++;
            $display("FAIL release_cs got=cs%b_gnt%b exp=cs111_gnt000", cs_n, gnt);
        end
        extra = 0;
        repeat (20) begin
            tick();
            if (sck_rise === 1'b1 || sck === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin failures++; $display("FAIL release_no_rise got=%0d exp=0", extra); end
    endtask

    task automatic test_setup_drop();
        int t0, edges;
        req_div = 6'b0;
        req = 3'b001;
        wait_cs_low(0, t0);
        req = 3'b000;
        tick();
        checks++;
        if ((cs_n !== 3'b111) || (gnt !== 3'b000)) begin
            failures++;
            $display("FAIL setup_drop_cs got=cs%b_gnt%b exp=cs111_gnt000", cs_n, gnt);
        end
        edges = 0;
        repeat (10) begin
            tick();
            if (sck_rise === 1'b1 || sck_fall === 1'b1) edges++;
        end
        checks++;
        if (edges != 0) begin failures++; $display("FAIL setup_drop_edges got=%0d exp=0", edges); end
    endtask

    task automatic test_lock_loss();
        int t0, tr;
        req_div = 6'b00_00_01;
        req = 3'b001;
        wait_cs_low(0, t0);
        wait_rise(tr);
        pll_lock = 1'b0;
        tick();
        checks++;
        if ({gnt, cs_n, sck, abort, ready} !== {3'b000, 3'b111, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL lock_loss got=gnt%b_cs%b_sck%b_abort%b_ready%b exp=gnt000_cs111_sck0_abort1_ready0",
                     gnt, cs_n, sck, abort, ready);
        end
        tick();
        checks++;
        if (abort !== 1'b0) begin failures++; $display("FAIL lock_loss_abort_width got=%0b exp=0", abort); end
        req = 3'b000;
        bring_up();
    endtask

    task automatic test_reset_mid();
        int t0, tr;
        req_div = 6'b0;
        req = 3'b010;
        wait_cs_low(1, t0);
        wait_rise(tr);
        rst = 1'b1;
        tick();
        checks++;
        if ({gnt, cs_n, sck, sck_rise, sck_fall, ready, abort} !== {3'b000, 3'b111, 5'b00000}) begin
            failures++;
            $display("FAIL reset_mid got=%b_%b_%b%b%b%b%b exp=000_111_00000",
                     gnt, cs_n, sck, sck_rise, sck_fall, ready, abort);
        end
        rst = 1'b0;
        req = 3'b000;
        bring_up();
    endtask

    initial begin
        test_reset();
        test_lock_qualify();
        test_round_robin();
        test_speed();
        test_release();
        test_setup_drop();
        test_lock_loss();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
